fpu_issue: RTL and testbench

- Sequencer between the core's execute stage and the FPU controller.
- Accepts one FP request (op, two operands), latches it, and drives the FPU stb/ack handshake: operand A, then operand B, then result.
- Holds `busy` to stall the pipeline, captures the result, and pulses `done` for writeback.
- `op` stays stable for the whole transaction because the FPU controller muxes its datapath by op.

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fpu_issue.sv | 149 ++++++++++++++
 tb/tb_fpu_issue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - op codes, FSM state type and helpers shared by the FPU issue sequencer
package fpu_pkg;

    localparam logic [3:0] FPU_FADD     = 4'b0000;
    localparam logic [3:0] FPU_FSUB     = 4'b0001;
    localparam logic [3:0] FPU_FMUL     = 4'b0010;
    localparam logic [3:0] FPU_FDIV     = 4'b0011;
    localparam logic [3:0] FPU_FCVT_S_W = 4'b0100;
    localparam logic [3:0] FPU_FCVT_W_S = 4'b0101;
    localparam logic [3:0] FPU_FEQ      = 4'b0110;
    localparam logic [3:0] FPU_FLT      = 4'b0111;
    localparam logic [3:0] FPU_FLE      = 4'b1000;

    localparam logic [31:0] FPU_CANONICAL_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_Z,
        ST_DONE
    } fpu_issue_state_t;

    // Only the ops the attached FPU controller implements today.
    function automatic logic is_supported_op(input logic [3:0] op);
        return (op == FPU_FADD) || (op == FPU_FSUB) || (op == FPU_FMUL);
    endfunction

endpackage

// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - sequencer from execute stage to FPU stb/ack handshake; optional watchdog via FPU_TIMEOUT_EN
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal,
    output logic        timeout,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic        fpu_in1_stb,
    input  logic        fpu_in1_ack,
    output logic        fpu_in2_stb,
    input  logic        fpu_in2_ack,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_stb,
    output logic        fpu_out_ack
);

    fpu_issue_state_t state, state_next;
    logic             illegal_q;
    logic             timeout_q;
    logic             wait_expired;

`ifdef FPU_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Count cycles spent in the current wait state; restart on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign wait_expired = busy && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout      = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_timeout_q;

    assign wait_expired     = 1'b0;
    assign timeout          = 1'b0;
    assign unused_timeout_q = timeout_q;
`endif

    assign busy        = (state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_WAIT_Z);
    assign done        = (state == ST_DONE);
    assign illegal     = illegal_q;
    assign fpu_in1_stb = (state == ST_SEND_A);
    assign fpu_in2_stb = (state == ST_SEND_B);
    assign fpu_out_ack = (state == ST_WAIT_Z) && fpu_out_stb;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a completed handshake wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = is_supported_op(op) ? ST_SEND_A : ST_DONE;
                end
            end
            ST_SEND_A: begin
                if (fpu_in1_ack)       state_next = ST_SEND_B;
                else if (wait_expired) state_next = ST_DONE;
            end
            ST_SEND_B: begin
                if (fpu_in2_ack)       state_next = ST_WAIT_Z;
                else if (wait_expired) state_next = ST_DONE;
            end
            ST_WAIT_Z: begin
                if (fpu_out_stb || wait_expired) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Latch the request, capture the result and set the done qualifiers for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_op    <= '0;
            fpu_in1   <= '0;
            fpu_in2   <= '0;
            result    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_supported_op(op)) begin
                        fpu_op  <= op;
                        fpu_in1 <= rs1_val;
                        fpu_in2 <= rs2_val;
                    end else if (start) begin
                        result    <= '0;
                        illegal_q <= 1'b1;
                    end
                end
                ST_SEND_A: begin
                    if (!fpu_in1_ack && wait_expired) begin
                        result    <= FPU_CANONICAL_NAN;
                        timeout_q <= 1'b1;
                    end
                end
                ST_SEND_B: begin
                    if (!fpu_in2_ack && wait_expired) begin
                        result    <= FPU_CANONICAL_NAN;
                        timeout_q <= 1'b1;
                    end
                end
                ST_WAIT_Z: begin
                    if (fpu_out_stb) begin
                        result <= fpu_out;
                    end else if (wait_expired) begin
                        result    <= FPU_CANONICAL_NAN;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - directed self-checking bench for fpu_issue
module tb_fpu_issue;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;
    logic        timeout;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_in1;
    logic [31:0] fpu_in2;
    logic        fpu_in1_stb;
    logic        fpu_in1_ack;
    logic        fpu_in2_stb;
    logic        fpu_in2_ack;
    logic [31:0] fpu_out;
    logic        fpu_out_stb;
    logic        fpu_out_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int hs1_cnt  = 0;
    int hs2_cnt  = 0;
    int stb_cnt  = 0;

    fpu_issue #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .illegal     (illegal),
        .timeout     (timeout),
        .fpu_op      (fpu_op),
        .fpu_in1     (fpu_in1),
        .fpu_in2     (fpu_in2),
        .fpu_in1_stb (fpu_in1_stb),
        .fpu_in1_ack (fpu_in1_ack),
        .fpu_in2_stb (fpu_in2_stb),
        .fpu_in2_ack (fpu_in2_ack),
        .fpu_out     (fpu_out),
        .fpu_out_stb (fpu_out_stb),
        .fpu_out_ack (fpu_out_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    // Handshake and strobe activity, sampled mid-cycle after stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (fpu_in1_stb && fpu_in1_ack) hs1_cnt++;
        if (fpu_in2_stb && fpu_in2_ack) hs2_cnt++;
        if (fpu_in1_stb || fpu_in2_stb || fpu_out_ack) stb_cnt++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] z, input int lat,
                          input bit restart);
        int h1;
        int h2;
        h1 = hs1_cnt;
        h2 = hs2_cnt;
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        @(negedge clk);
        start   = 1'b0;
        rs1_val = 32'h0;
        rs2_val = 32'h0;
        op      = 4'b1111;
        chk1 ({tag, " send_a busy"}, busy, 1'b1);
        chk1 ({tag, " send_a in1_stb"}, fpu_in1_stb, 1'b1);
        chk1 ({tag, " send_a in2_stb"}, fpu_in2_stb, 1'b0);
        chk32({tag, " send_a fpu_op"}, 32'(fpu_op), 32'(o));
        chk32({tag, " send_a fpu_in1"}, fpu_in1, a);
        @(negedge clk);
        chk1 ({tag, " send_b in1_stb"}, fpu_in1_stb, 1'b0);
        chk1 ({tag, " send_b in2_stb"}, fpu_in2_stb, 1'b1);
        chk32({tag, " send_b fpu_in2"}, fpu_in2, b);
        chk32({tag, " send_b fpu_op"}, 32'(fpu_op), 32'(o));
        @(negedge clk);
        for (int i = 0; i < lat; i++) begin
            chk1({tag, " wait_z busy"}, busy, 1'b1);
            chk1({tag, " wait_z out_ack idle"}, fpu_out_ack, 1'b0);
            @(negedge clk);
        end
        fpu_out_stb = 1'b1;
        fpu_out     = z;
        #1;
        chk1({tag, " wait_z out_ack"}, fpu_out_ack, 1'b1);
        @(negedge clk);
        fpu_out_stb = 1'b0;
        fpu_out     = 32'hDEAD_BEEF;
        if (restart) begin
            start   = 1'b1;
            op      = 4'b0000;
            rs1_val = 32'h3F80_0000;
            rs2_val = 32'h4000_0000;
        end
        chk1 ({tag, " done"}, done, 1'b1);
        chk1 ({tag, " done busy"}, busy, 1'b0);
        chk32({tag, " result"}, result, z);
        chk1 ({tag, " illegal"}, illegal, 1'b0);
        chk1 ({tag, " timeout"}, timeout, 1'b0);
        chk32({tag, " in1 handshakes"}, 32'(hs1_cnt - h1), 32'd1);
        chk32({tag, " in2 handshakes"}, 32'(hs2_cnt - h2), 32'd1);
        @(negedge clk);
        chk1 ({tag, " after done"}, done, 1'b0);
        chk1 ({tag, " after done busy"}, busy, 1'b0);
        chk32({tag, " result held"}, result, z);
    endtask

    initial begin
        int s0;
        rst         = 1'b1;
        start       = 1'b0;
        op          = 4'b0000;
        rs1_val     = 32'h0;
        rs2_val     = 32'h0;
        fpu_in1_ack = 1'b1;
        fpu_in2_ack = 1'b1;
        fpu_out     = 32'h0;
        fpu_out_stb = 1'b1;

        @(negedge clk);
        chk1 ("reset busy", busy, 1'b0);
        chk1 ("reset done", done, 1'b0);
        chk32("reset result", result, 32'h0);
        chk1 ("reset in1_stb", fpu_in1_stb, 1'b0);
        chk1 ("reset out_ack", fpu_out_ack, 1'b0);
        chk32("reset fpu_in1", fpu_in1, 32'h0);
        rst = 1'b0;

        // Stray acks and result strobe while idle must not move the FSM.
        @(negedge clk);
        @(negedge clk);
        chk1("stray busy", busy, 1'b0);
        chk1("stray done", done, 1'b0);
        chk1("stray out_ack", fpu_out_ack, 1'b0);
        fpu_out_stb = 1'b0;

        run_op("fadd", 4'b0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2, 1'b0);
        run_op("fsub", 4'b0001, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 0, 1'b0);
        run_op("fmul", 4'b0010, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3, 1'b1);
        run_op("fadd2", 4'b0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1, 1'b0);

        // Unsupported op completes on the next cycle without touching the FPU.
        s0      = stb_cnt;
        start   = 1'b1;
        op      = 4'b0100;
        rs1_val = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        chk1 ("illegal done", done, 1'b1);
        chk1 ("illegal flag", illegal, 1'b1);
        chk32("illegal result", result, 32'h0);
        chk1 ("illegal busy", busy, 1'b0);
        @(negedge clk);
        chk1 ("illegal after done", done, 1'b0);
        chk1 ("illegal after flag", illegal, 1'b0);
        chk32("illegal no strobes", 32'(stb_cnt - s0), 32'd0);
        run_op("fsub3", 4'b0001, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0);

        // Reset in the middle of a transaction.
        start   = 1'b1;
        op      = 4'b0000;
        rs1_val = 32'h3F80_0000;
        rs2_val = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk1("rst pre in2_stb", fpu_in2_stb, 1'b1);
        rst = 1'b1;
        #1;
        chk1 ("rst busy", busy, 1'b0);
        chk1 ("rst in2_stb", fpu_in2_stb, 1'b0);
        chk32("rst result", result, 32'h0);
        chk32("rst fpu_in1", fpu_in1, 32'h0);
        chk32("rst fpu_in2", fpu_in2, 32'h0);
        @(negedge clk);
        chk1("rst done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("post rst done", done, 1'b0);
        chk1("post rst busy", busy, 1'b0);
        run_op("post rst fadd", 4'b0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1, 1'b0);

`ifdef FPU_TIMEOUT_EN
        // Operand A is never consumed; the watchdog aborts after 8 SEND_A cycles.
        fpu_in1_ack = 1'b0;
        start       = 1'b1;
        op          = 4'b0010;
        rs1_val     = 32'h3F80_0000;
        rs2_val     = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk1("to send_a in1_stb", fpu_in1_stb, 1'b1);
            chk1("to send_a done", done, 1'b0);
            start = (i == 2);
            op    = (i == 2) ? 4'b0000 : 4'b0010;
            @(negedge clk);
        end
        start = 1'b0;
        chk1 ("to done", done, 1'b1);
        chk1 ("to timeout", timeout, 1'b1);
        chk1 ("to illegal", illegal, 1'b0);
        chk32("to result", result, 32'h7FC0_0000);
        chk1 ("to in1_stb", fpu_in1_stb, 1'b0);
        chk32("to fpu_op kept", 32'(fpu_op), 32'd2);
        @(negedge clk);
        chk1("to after done", done, 1'b0);
        chk1("to after timeout", timeout, 1'b0);
        chk1("to after in1_stb", fpu_in1_stb, 1'b0);
        chk1("to after busy", busy, 1'b0);
        fpu_in1_ack = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
